// File: rtl/patch_stream_vectorizer.sv
// rtl/patch_stream_vectorizer.sv - buffers one band of PATCH image rows and streams it out patch by patch
module patch_stream_vectorizer #(
  parameter  int CHANNEL_SIZE = 8,
  parameter  int NUM_CHANNELS = 3,
  parameter  int PATCH        = 16,
  parameter  int IMG_W        = 64,
  parameter  int IMG_H        = 64,
  localparam int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
  localparam int NPW          = IMG_W / PATCH,
  localparam int NPH          = IMG_H / PATCH,
  localparam int NP           = NPW * NPH,
  localparam int PW           = (NP > 1) ? $clog2(NP) : 1,
  localparam int QW           = $clog2(PATCH * PATCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic [PW-1:0]          out_patch_idx,
  output logic [QW-1:0]          out_pos_idx,
  output logic                   out_patch_last,
  output logic                   out_frame_last,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int RW = (PATCH > 1) ? $clog2(PATCH) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int XW = (NPW > 1) ? $clog2(NPW) : 1;
  localparam int BW = (NPH > 1) ? $clog2(NPH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // band buffer: PATCH rows of the full image width
  logic [PIXEL_WIDTH-1:0] buf_mem [PATCH][IMG_W];

  logic [RW-1:0] r_q;
  logic [CW-1:0] c_q;
  logic [RW-1:0] pr_q;
  logic [RW-1:0] pc_q;
  logic [XW-1:0] px_q;
  logic [BW-1:0] band_q;
  logic          frame_done_q;

  logic          in_fire, out_fire;
  logic          last_c, last_r, last_pc, last_pr, last_px, last_band;
  logic          fill_done, band_done;
  logic [CW-1:0] rd_col;

  // abort kills any handshake in the same cycle, so the beat is never consumed
  assign in_fire   = in_valid && (state_q == FILL) && !abort;
  assign out_fire  = (state_q == DRAIN) && out_ready && !abort;

  assign last_c    = (c_q == CW'(IMG_W - 1));
  assign last_r    = (r_q == RW'(PATCH - 1));
  assign last_pc   = (pc_q == RW'(PATCH - 1));
  assign last_pr   = (pr_q == RW'(PATCH - 1));
  assign last_px   = (px_q == XW'(NPW - 1));
  assign last_band = (band_q == BW'(NPH - 1));

  assign fill_done = in_fire && last_r && last_c;
  assign band_done = out_fire && last_pr && last_pc && last_px;

  assign rd_col         = CW'(int'(px_q) * PATCH + int'(pc_q));
  assign in_ready       = (state_q == FILL);
  assign out_valid      = (state_q == DRAIN);
  assign out_pixel      = buf_mem[pr_q][rd_col];
  assign out_patch_idx  = PW'(int'(band_q) * NPW + int'(px_q));
  assign out_pos_idx    = QW'(int'(pr_q) * PATCH + int'(pc_q));
  assign out_patch_last = last_pr && last_pc;
  assign out_frame_last = last_pr && last_pc && last_px && last_band;
  assign frame_done     = frame_done_q;
  assign busy           = (state_q != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: fill a band, drain it, repeat until the last band is out
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (fill_done) state_d = DRAIN;
      DRAIN:   if (band_done) state_d = last_band ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // buffer write; contents need no reset since every slot is rewritten before it is read
  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[r_q][c_q] <= in_pixel;
  end

  // raster write counters and patch read counters
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_q    <= '0;
      c_q    <= '0;
      pr_q   <= '0;
      pc_q   <= '0;
      px_q   <= '0;
      band_q <= '0;
    end else begin
      if (in_fire) begin
        if (last_c) begin
          c_q <= '0;
          r_q <= last_r ? '0 : r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
      if (out_fire) begin
        if (last_pc) begin
          pc_q <= '0;
          if (last_pr) begin
            pr_q <= '0;
            if (last_px) begin
              px_q   <= '0;
              band_q <= last_band ? '0 : band_q + 1'b1;
            end else begin
              px_q <= px_q + 1'b1;
            end
          end else begin
            pr_q <= pr_q + 1'b1;
          end
        end else begin
          pc_q <= pc_q + 1'b1;
        end
      end
    end
  end

  // one-cycle completion pulse after the final beat of the frame
  always_ff @(posedge clk) begin
    if (reset || abort) frame_done_q <= 1'b0;
    else                frame_done_q <= band_done && last_band;
  end

endmodule

// File: tb/tb_patch_stream_vectorizer.sv
// tb/tb_patch_stream_vectorizer.sv - scoreboard bench for patch_stream_vectorizer (PATCH=4, 8x8 image)
module tb_patch_stream_vectorizer;

  localparam int PATCH = 4;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int PXW   = 24;
  localparam int PW    = 2;
  localparam int QW    = 4;
  localparam int BAND_BEATS = PATCH * IMG_W;

  typedef struct {
    logic [PXW-1:0] pix;
    logic [PW-1:0]  pidx;
    logic [QW-1:0]  pos;
    logic           plast;
    logic           flast;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset, start, abort, in_valid, out_ready;
  logic [PXW-1:0] in_pixel;
  logic           in_ready, out_valid, out_patch_last, out_frame_last, frame_done, busy;
  logic [PXW-1:0] out_pixel;
  logic [PW-1:0]  out_patch_idx;
  logic [QW-1:0]  out_pos_idx;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    plast_cnt, flast_cnt;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  patch_stream_vectorizer #(
    .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .PATCH(PATCH), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx),
    .out_patch_last(out_patch_last), .out_frame_last(out_frame_last),
    .frame_done(frame_done), .busy(busy)
  );

  // expected output order of band b, pushed when its input is driven
  task automatic push_band(input int b);
    beat_t e;
    for (int px = 0; px < IMG_W / PATCH; px++)
      for (int pr = 0; pr < PATCH; pr++)
        for (int pc = 0; pc < PATCH; pc++) begin
          e.pix   = PXW'((b * PATCH + pr) * IMG_W + px * PATCH + pc);
          e.pidx  = PW'(b * (IMG_W / PATCH) + px);
          e.pos   = QW'(pr * PATCH + pc);
          e.plast = (pr == PATCH - 1) && (pc == PATCH - 1);
          e.flast = e.plast && (px == IMG_W / PATCH - 1) && (b == IMG_H / PATCH - 1);
          exp_q.push_back(e);
        end
  endtask

  task automatic feed(input int b, input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    push_band(b);
    while (i < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_pixel = PXW'((b * PATCH + i / IMG_W) * IMG_W + i % IMG_W);
      end
      if (in_valid && in_ready) i++;
    end
    n_checks++;
    if (i != n) begin
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d required %0d", i, n);
    end
  endtask

  task automatic drain(input int n, input bit rnd, input bit poke, input bit last_band);
    int    got = 0;
    int    guard = 0;
    bit    stalled = 1'b0;
    bit    first = 1'b1;
    beat_t h, e;
    while (got < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid  = 1'b0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (first) begin
        first = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_latency: out_valid=%b required 1", out_valid);
        end
      end
      if (out_valid) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_in_drain: got %b required 0", in_ready);
        end
        if (stalled) begin
          n_checks++;
          if (out_pixel !== h.pix || out_patch_idx !== h.pidx || out_pos_idx !== h.pos ||
              out_patch_last !== h.plast || out_frame_last !== h.flast) begin
            n_fail++;
            $display("FAIL stall_stable: pix %0d/%0d idx %0d/%0d pos %0d/%0d",
                     out_pixel, h.pix, out_patch_idx, h.pidx, out_pos_idx, h.pos);
          end
        end
        if (out_ready) begin
          stalled = 1'b0;
          got++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: pix %0d with empty scoreboard", out_pixel);
          end else begin
            e = exp_q.pop_front();
            if (out_pixel !== e.pix || out_patch_idx !== e.pidx || out_pos_idx !== e.pos ||
                out_patch_last !== e.plast || out_frame_last !== e.flast) begin
              n_fail++;
              $display("FAIL beat: pix %0d req %0d, idx %0d req %0d, pos %0d req %0d, pl %b req %b, fl %b req %b",
                       out_pixel, e.pix, out_patch_idx, e.pidx, out_pos_idx, e.pos,
                       out_patch_last, e.plast, out_frame_last, e.flast);
            end
          end
          if (out_patch_last) plast_cnt++;
          if (out_frame_last) flast_cnt++;
        end else begin
          stalled = 1'b1;
          h.pix = out_pixel; h.pidx = out_patch_idx; h.pos = out_pos_idx;
          h.plast = out_patch_last; h.flast = out_frame_last;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL drain_timeout: beats %0d required %0d", got, n);
    end
  endtask

  task automatic run_frame(input bit gaps, input bit rnd, input bit poke);
    plast_cnt = 0;
    flast_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_to_fill: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    for (int b = 0; b < IMG_H / PATCH; b++) begin
      feed(b, BAND_BEATS, gaps);
      drain(BAND_BEATS, rnd, poke, b == IMG_H / PATCH - 1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_pulse: done=%b busy=%b ov=%b required 1 0 0", frame_done, busy, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_width: got %b required 0", frame_done);
    end
    n_checks++;
    if (plast_cnt != 4 || flast_cnt != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_totals: plast %0d req 4, flast %0d req 1, leftover %0d req 0",
               plast_cnt, flast_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b ir=%b ov=%b fd=%b required 0 0 0 0",
               busy, in_ready, out_valid, frame_done);
    end
  endtask

  task automatic test_basic;        run_frame(1'b0, 1'b0, 1'b0); endtask
  task automatic test_backpressure; run_frame(1'b0, 1'b1, 1'b0); endtask
  task automatic test_input_gaps;   run_frame(1'b1, 1'b0, 1'b0); endtask
  task automatic test_start_in_drain; run_frame(1'b1, 1'b1, 1'b1); endtask

  task automatic test_abort;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(0, BAND_BEATS, 1'b0);
    drain(PATCH * PATCH + 10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: ov=%b busy=%b ir=%b required 0 0 0", out_valid, busy, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: fd=%b busy=%b required 0 0", frame_done, busy);
      end
    end
    exp_q.delete();
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fill;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(0, 10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: busy=%b ir=%b ov=%b required 0 0 0", busy, in_ready, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_abort();
    test_start_in_drain();
    test_reset_mid_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
